// File: rtl/inst_d_pkg.sv
// Shared types for the decode stage: opcode enum, control bundle and ID/EX payload.
package inst_d_pkg;

  localparam int NREG_ADDR_W = 5;
  localparam int XW          = 32;

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000, OP_ADDI = 6'b000001,
    OP_SUB  = 6'b000010, OP_SUBI = 6'b000011,
    OP_MUL  = 6'b000100, OP_MULI = 6'b000101,
    OP_OR   = 6'b000110, OP_ORI  = 6'b000111,
    OP_AND  = 6'b001000, OP_ANDI = 6'b001001,
    OP_XOR  = 6'b001010, OP_XORI = 6'b001011,
    OP_LDW  = 6'b001100, OP_STW  = 6'b001101,
    OP_BZ   = 6'b001110, OP_BEQ  = 6'b001111,
    OP_JR   = 6'b010000, OP_HALT = 6'b010001
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic halt;
  } ctrl_t;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic                   valid;
    logic [5:0]             opcode;
    logic [XW-1:0]          pc;
    logic [XW-1:0]          rs_val;
    logic [XW-1:0]          rt_val;
    logic [XW-1:0]          imm;
    logic [NREG_ADDR_W-1:0] dest;
    ctrl_t                  ctrl;
  } idex_t;

endpackage

// File: rtl/inst_d_reg_file.sv
// 2R/1W register file, R0 hard-wired to zero. Define INST_D_WB_BYPASS_EN for
// same-cycle write-through from the write port to the read ports.
module reg_file
  import inst_d_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [NREG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic [NREG_ADDR_W-1:0] raddr_a,
  input  logic [NREG_ADDR_W-1:0] raddr_b,
  output logic [XLEN-1:0]        rdata_a,
  output logic [XLEN-1:0]        rdata_b
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            hit_a, hit_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

`ifdef INST_D_WB_BYPASS_EN
  assign hit_a = we && (waddr != '0) && (waddr == raddr_a);
  assign hit_b = we && (waddr != '0) && (waddr == raddr_b);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  assign rdata_a = (raddr_a == '0) ? '0 : hit_a ? wdata : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : hit_b ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/inst_d.sv
// Decode stage: IF/ID register, register file, opcode decode and ID/EX register.
// Optional write-through on the register file under INST_D_WB_BYPASS_EN.
module inst_d
  import inst_d_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        if_instruction,
  input  logic [XLEN-1:0]        if_pc,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [NREG_ADDR_W-1:0] wb_dest,
  input  logic [XLEN-1:0]        wb_data,
  output logic [NREG_ADDR_W-1:0] rs_f_id,
  output logic [NREG_ADDR_W-1:0] rt_f_id,
  output logic [NREG_ADDR_W-1:0] rd_f_id,
  output logic [NREG_ADDR_W-1:0] id_dest,
  output logic                   ex_valid,
  output logic [5:0]             ex_opcode,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_rs_val,
  output logic [XLEN-1:0]        ex_rt_val,
  output logic [XLEN-1:0]        ex_imm,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic                   ex_halt,
  output logic                   halted
);

  logic                   ifid_valid_q;
  logic [XLEN-1:0]        ifid_instr_q, ifid_pc_q;
  idex_t                  idex_q, idex_d;
  logic                   halted_q;

  logic [5:0]             op;
  ctrl_t                  dec_ctrl;
  logic [NREG_ADDR_W-1:0] dec_dest;
  logic                   dec_legal;
  logic [XLEN-1:0]        rs_val, rt_val;

  assign op      = ifid_instr_q[31:26];
  assign rs_f_id = ifid_instr_q[25:21];
  assign rt_f_id = ifid_instr_q[20:16];
  assign rd_f_id = ifid_instr_q[15:11];

  reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_dest),
    .wdata   (wb_data),
    .raddr_a (rs_f_id),
    .raddr_b (rt_f_id),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  always_comb begin
    dec_ctrl  = '0;
    dec_dest  = '0;
    dec_legal = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        dec_legal = 1'b1; dec_dest = rd_f_id; dec_ctrl.reg_write = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        dec_legal = 1'b1; dec_dest = rt_f_id; dec_ctrl.reg_write = 1'b1;
      end
      OP_LDW: begin
        dec_legal = 1'b1; dec_dest = rt_f_id;
        dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_read = 1'b1;
      end
      OP_STW:              begin dec_legal = 1'b1; dec_ctrl.mem_write = 1'b1; end
      OP_BZ, OP_BEQ, OP_JR: begin dec_legal = 1'b1; dec_ctrl.branch = 1'b1; end
      OP_HALT:             begin dec_legal = 1'b1; dec_ctrl.halt = 1'b1; end
      default: ;
    endcase
    if (dec_dest == '0) dec_ctrl.reg_write = 1'b0;
  end

  // Unknown opcodes and empty IF/ID slots both become a full bubble.
  always_comb begin
    idex_d = '0;
    if (ifid_valid_q && dec_legal) begin
      idex_d.valid  = 1'b1;
      idex_d.opcode = op;
      idex_d.pc     = ifid_pc_q;
      idex_d.rs_val = rs_val;
      idex_d.rt_val = rt_val;
      idex_d.imm    = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
      idex_d.dest   = dec_dest;
      idex_d.ctrl   = dec_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_q       <= '0;
      halted_q     <= 1'b0;
    end else if (flush) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_q       <= '0;
    end else if (stall) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
      // The instruction behind a HALT is dropped on the same edge HALT advances.
      if (halted_q || idex_d.ctrl.halt) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= '0;
        ifid_pc_q    <= '0;
      end else begin
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= if_instruction;
        ifid_pc_q    <= if_pc;
      end
      if (idex_d.ctrl.halt) halted_q <= 1'b1;
    end
  end

  assign id_dest      = idex_q.dest;
  assign ex_valid     = idex_q.valid;
  assign ex_opcode    = idex_q.opcode;
  assign ex_pc        = idex_q.pc;
  assign ex_rs_val    = idex_q.rs_val;
  assign ex_rt_val    = idex_q.rt_val;
  assign ex_imm       = idex_q.imm;
  assign ex_reg_write = idex_q.ctrl.reg_write;
  assign ex_mem_read  = idex_q.ctrl.mem_read;
  assign ex_mem_write = idex_q.ctrl.mem_write;
  assign ex_branch    = idex_q.ctrl.branch;
  assign ex_halt      = idex_q.ctrl.halt;
  assign halted       = halted_q;

endmodule
